bram_sdp_pipelined: RTL

BRAM_SDP_PIPELINED -- requirements
Module: bram_sdp_pipelined

---
 rtl/bram_sdp_pipelined.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/bram_sdp_pipelined.sv
// Simple dual-port RAM with per-lane write enables and a READ_LATENCY-deep (1..3) read pipeline.
// Define BRAM_INIT_CLEAR_EN to zero the array after every reset; busy drops requests while it runs.
module bram_sdp_pipelined #(
  parameter int RAM_WIDTH      = 32,
  parameter int RAM_DEPTH      = 256,
  parameter int BYTE_WIDTH     = 8,
  parameter int READ_LATENCY   = 2,
  parameter int COLLISION_MODE = 0,
  localparam int AW = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1,
  localparam int NB = RAM_WIDTH / BYTE_WIDTH
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 wr_en,
  input  logic [AW-1:0]        wr_addr,
  input  logic [RAM_WIDTH-1:0] wr_data,
  input  logic [NB-1:0]        wr_be,
  input  logic                 rd_en,
  input  logic [AW-1:0]        rd_addr,
  output logic [RAM_WIDTH-1:0] rd_data,
  output logic                 rd_valid,
  output logic                 busy
);

  logic [RAM_WIDTH-1:0] mem [RAM_DEPTH];

  logic                 wr_in_range;
  logic                 rd_in_range;
  logic                 wr_ok;
  logic                 rd_ok;
  logic [RAM_WIDTH-1:0] wr_mask;
  logic [RAM_WIDTH-1:0] rd_word;
  logic                 clr_we;
  logic [AW-1:0]        clr_addr;

  assign wr_in_range = ({{(32-AW){1'b0}}, wr_addr} < 32'(RAM_DEPTH));
  assign rd_in_range = ({{(32-AW){1'b0}}, rd_addr} < 32'(RAM_DEPTH));
  assign wr_ok       = wr_en && !busy && !rst_in && wr_in_range;
  // Out-of-range reads are still accepted; they just return zero.
  assign rd_ok       = rd_en && !busy && !rst_in;

  always_comb begin
    wr_mask = '0;
    for (int i = 0; i < NB; i++) begin
      wr_mask[i*BYTE_WIDTH +: BYTE_WIDTH] = {BYTE_WIDTH{wr_be[i]}};
    end
  end

`ifdef BRAM_INIT_CLEAR_EN
  typedef enum logic {CLEAR, READY} state_t;

  state_t        state;
  state_t        state_nxt;
  logic [AW-1:0] clr_cnt;
  logic [AW-1:0] clr_cnt_nxt;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state   <= CLEAR;
      clr_cnt <= '0;
    end else begin
      state   <= state_nxt;
      clr_cnt <= clr_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    clr_cnt_nxt = clr_cnt;
    clr_we      = 1'b0;
    clr_addr    = clr_cnt;
    case (state)
      CLEAR: begin
        clr_we      = !rst_in;
        clr_cnt_nxt = clr_cnt + 1'b1;
        if (clr_cnt == AW'(RAM_DEPTH - 1)) begin
          state_nxt = READY;
        end
      end
      default: begin
        state_nxt = READY;
      end
    endcase
  end

  assign busy = (state == CLEAR);
`else
  assign busy     = 1'b0;
  assign clr_we   = 1'b0;
  assign clr_addr = '0;
`endif

  // Clear sweep and user writes never coincide: busy blocks user writes.
  always_ff @(posedge clk_in) begin
    if (clr_we) begin
      mem[clr_addr] <= '0;
    end else if (wr_ok) begin
      for (int i = 0; i < NB; i++) begin
        if (wr_be[i]) begin
          mem[wr_addr][i*BYTE_WIDTH +: BYTE_WIDTH] <= wr_data[i*BYTE_WIDTH +: BYTE_WIDTH];
        end
      end
    end
  end

  // Array value is sampled before this edge's write lands, giving read-first by default.
  always_comb begin
    rd_word = '0;
    if (rd_in_range) begin
      rd_word = mem[rd_addr];
      if (COLLISION_MODE == 1 && wr_ok && wr_addr == rd_addr) begin
        rd_word = (rd_word & ~wr_mask) | (wr_data & wr_mask);
      end
    end
  end

  logic [READ_LATENCY-1:0] pipe_vld;
  logic [RAM_WIDTH-1:0]    pipe_dat [READ_LATENCY];

  // Data registers only load alongside a valid, so the last stage holds between results.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      pipe_vld <= '0;
      for (int i = 0; i < READ_LATENCY; i++) begin
        pipe_dat[i] <= '0;
      end
    end else begin
      pipe_vld[0] <= rd_ok;
      if (rd_ok) begin
        pipe_dat[0] <= rd_word;
      end
      for (int i = 1; i < READ_LATENCY; i++) begin
        pipe_vld[i] <= pipe_vld[i-1];
        if (pipe_vld[i-1]) begin
          pipe_dat[i] <= pipe_dat[i-1];
        end
      end
    end
  end

  assign rd_valid = pipe_vld[READ_LATENCY-1];
  assign rd_data  = pipe_dat[READ_LATENCY-1];

endmodule
